// File: rtl/task3_pkg.sv
// ---------------------------------------------------------------------------
// task3_pkg
// Shared definitions for the task3 serial link (transmitter and receiver).
//   - link FSM state encoding
//   - line-level constants (start, stop, idle levels)
//   - default payload width
//   - parity helper used by task3_parity
// No ports (package).
// ---------------------------------------------------------------------------
package task3_pkg;

  localparam int DEFAULT_DATA_W = 32;

  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam logic IDLE_LEVEL = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Parity bit that makes XOR(data, parity) equal to the odd flag.
  function automatic logic calc_parity(input logic reduced_xor, input logic odd);
    return reduced_xor ^ odd;
  endfunction

endpackage

// File: rtl/task3_parity.sv
// ---------------------------------------------------------------------------
// task3_parity
// Combinational parity generator shared by the task3 transmitter and receiver.
// Ports:
//   data   in  DATA_W  word to protect
//   parity out 1       parity bit to send / expect with this word
// PARITY_ODD = 0 gives even parity, 1 gives odd parity.
// ---------------------------------------------------------------------------
module task3_parity
  import task3_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int PARITY_ODD = 0
) (
  input  logic [DATA_W-1:0] data,
  output logic              parity
);

  localparam logic ODD_FLAG = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  assign parity = calc_parity(^data, ODD_FLAG);

endmodule

// File: rtl/task3_rx.sv
// ---------------------------------------------------------------------------
// task3_rx
// Serial receiver for the task3 link. One bit is sampled per clock; a frame is
// start(1), DATA_W data bits LSB first, parity, stop(0).
// Ports:
//   clock       in   1       system clock, rising edge
//   reset_n     in   1       asynchronous active-low reset
//   serial_in   in   1       line from the transmitter
//   data_out    out  DATA_W  last word received with a good stop bit
//   valid       out  1       one-cycle pulse, data_out just updated
//   parity_err  out  1       one-cycle pulse with valid on parity mismatch
//   frame_err   out  1       one-cycle pulse when the stop bit is 1
//   busy        out  1       high while a frame is in progress
// ---------------------------------------------------------------------------
module task3_rx
  import task3_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int PARITY_ODD = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              serial_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t             state_r;
  state_t             next_state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [DATA_W-1:0]  shift_r;
  logic               parity_bit_r;
  logic               exp_parity_s;

  logic               load_s;
  logic               valid_s;
  logic               perr_s;
  logic               ferr_s;
  logic               busy_s;

  logic [DATA_W-1:0]  data_r;
  logic               valid_r;
  logic               perr_r;
  logic               ferr_r;
  logic               busy_r;

  // Expected parity of the assembled word; shift_r is complete by STOP.
  task3_parity #(
    .DATA_W     (DATA_W),
    .PARITY_ODD (PARITY_ODD)
  ) u_parity (
    .data   (shift_r),
    .parity (exp_parity_s)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic. A 1 seen in STOP is a frame error, not a new start.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (serial_in == START_BIT) begin
          next_state_s = DATA;
        end else begin
          next_state_s = IDLE;
        end
      end
      DATA: begin
        if (cnt_r == LAST_BIT) begin
          next_state_s = PARITY;
        end else begin
          next_state_s = DATA;
        end
      end
      PARITY:  next_state_s = STOP;
      STOP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode; results are registered on the stop-bit edge.
  always_comb begin
    load_s  = 1'b0;
    valid_s = 1'b0;
    perr_s  = 1'b0;
    ferr_s  = 1'b0;
    if (state_r == STOP) begin
      if (serial_in == STOP_BIT) begin
        load_s  = 1'b1;
        valid_s = 1'b1;
        perr_s  = (exp_parity_s != parity_bit_r);
      end else begin
        ferr_s  = 1'b1;
      end
    end else begin
      load_s  = 1'b0;
    end
    // Registering next_state != IDLE makes busy track state != IDLE.
    busy_s = (next_state_s != IDLE);
  end

  // Bit counter, right-shifting deserializer and parity capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r        <= '0;
      shift_r      <= '0;
      parity_bit_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (serial_in == START_BIT) begin
            cnt_r <= '0;
          end
        end
        DATA: begin
          // LSB arrives first, so after DATA_W shifts it sits in bit 0.
          shift_r <= {serial_in, shift_r[DATA_W-1:1]};
          cnt_r   <= cnt_r + CNT_W'(1);
        end
        PARITY: begin
          parity_bit_r <= serial_in;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Registered outputs; data_out only changes on a good stop bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_r  <= '0;
      valid_r <= 1'b0;
      perr_r  <= 1'b0;
      ferr_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      if (load_s) begin
        data_r <= shift_r;
      end
      valid_r <= valid_s;
      perr_r  <= perr_s;
      ferr_r  <= ferr_s;
      busy_r  <= busy_s;
    end
  end

  assign data_out   = data_r;
  assign valid      = valid_r;
  assign parity_err = perr_r;
  assign frame_err  = ferr_r;
  assign busy       = busy_r;

endmodule
